dmem_responder: RTL

Responder end of the processor's data-memory port: it accepts the word address, write data, and write enable the pipeline drives, and returns registered read data on `q_dmem`. It decodes a word-addressed RAM region and a small memory-mapped I/O window. The window holds a TX FIFO drained over a valid/ready stream, a status register, and a free-running cycle counter. It sits in the wrapper beside the regfile and instruction memory, in place of a bare dmem RAM.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_responder_tx_fifo.sv | 62 ++++++
 rtl/dmem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, region type and I/O decode helper for the dmem_responder slice.
// The CYCLES register decodes only when DMEM_CYCLE_COUNTER_EN is defined.
package dmem_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFF1;
  localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_FFF2;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_TXDATA,
    RGN_STATUS,
    RGN_CYCLES
  } region_e;

  // Decodes the I/O window only; RAM decode depends on the top's ADDR_WIDTH.
  function automatic region_e decode_io(input logic [31:0] addr);
    region_e rgn;
    rgn = RGN_NONE;
    case (addr)
      TXDATA_ADDR: rgn = RGN_TXDATA;
      STATUS_ADDR: rgn = RGN_STATUS;
`ifdef DMEM_CYCLE_COUNTER_EN
      CYCLES_ADDR: rgn = RGN_CYCLES;
`endif
      default:     rgn = RGN_NONE;
    endcase
    return rgn;
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// TX FIFO for the dmem_responder I/O window: power-of-two depth, natural-wrap
// pointers and a separate occupancy counter; a pop frees room for a same-cycle push.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [31:0]              push_data_i,
  input  logic                     pop_i,
  output logic [31:0]              head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     push_dropped_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_en, push_en;

  assign empty_o        = (count_q == '0);
  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign pop_en         = pop_i && !empty_o;
  assign push_en        = push_i && (!full_o || pop_en);
  assign push_dropped_o = push_i && full_o && !pop_en;
  assign count_o        = count_q;
  assign head_o         = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_en && !reset) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus an I/O window (TX FIFO, STATUS,
// optional CYCLES counter enabled by DMEM_CYCLE_COUNTER_EN); read latency of one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  region_e                 region, region_q;
  logic [ADDR_WIDTH-1:0]   ram_idx;
  logic                    wr_en;
  logic [31:0]             ram_q [2**ADDR_WIDTH];
  logic [31:0]             ram_rdata_q;
  logic [31:0]             io_rdata_d, io_rdata_q;
  logic [31:0]             status;
  logic [3:0]              count4;
  logic                    ovf_q, ovf_d;
  logic                    status_rd;
  logic                    fifo_empty, fifo_full, fifo_dropped;
  logic [CNT_W-1:0]        fifo_count;

  assign ram_idx   = address_dmem[ADDR_WIDTH-1:0];
  assign wr_en     = wren && !reset;
  assign status_rd = !wren && (region == RGN_STATUS);

  always_comb begin
    region = decode_io(address_dmem);
    if (address_dmem[31:ADDR_WIDTH] == '0) region = RGN_RAM;
  end

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock          (clock),
    .reset          (reset),
    .push_i         (wr_en && (region == RGN_TXDATA)),
    .push_data_i    (data),
    .pop_i          (io_tx_ready),
    .head_o         (io_tx_data),
    .empty_o        (fifo_empty),
    .full_o         (fifo_full),
    .count_o        (fifo_count),
    .push_dropped_o (fifo_dropped)
  );

  assign io_tx_valid = !fifo_empty;

  // Read-first: the registered read samples the old word even when this edge writes it.
  always_ff @(posedge clock) begin
    if (wr_en && (region == RGN_RAM)) ram_q[ram_idx] <= data;
    ram_rdata_q <= ram_q[ram_idx];
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clock) begin
    if (reset)                               cyc_q <= '0;
    else if (wren && (region == RGN_CYCLES)) cyc_q <= '0;
    else                                     cyc_q <= cyc_q + 32'd1;
  end
`endif

  assign count4 = 4'(fifo_count);

  always_comb begin
    status                        = '0;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_FULL]               = fifo_full;
    status[ST_OVF]                = ovf_q;
    status[ST_COUNT_LSB +: 4]     = count4;
  end

  // A dropped push in the same cycle as a STATUS read leaves overflow set.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_dropped)   ovf_d = 1'b1;
    else if (status_rd) ovf_d = 1'b0;
  end

  always_comb begin
    io_rdata_d = '0;
    case (region)
      RGN_STATUS: io_rdata_d = status;
`ifdef DMEM_CYCLE_COUNTER_EN
      RGN_CYCLES: io_rdata_d = cyc_q;
`endif
      default:    io_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      region_q   <= RGN_NONE;
      io_rdata_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      region_q   <= region;
      io_rdata_q <= io_rdata_d;
      ovf_q      <= ovf_d;
    end
  end

  assign q_dmem = (region_q == RGN_RAM) ? ram_rdata_q : io_rdata_q;

endmodule
